// File: rtl/fp_special_case_unit.sv
// fp_special_case_unit: two-stage IEEE-style special-operand resolver for add/sub/mul/div
module fp_special_case_unit #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter bit DAZ        = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    op,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] op1,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] op2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_special,
    output logic [EXP_WIDTH+MANT_WIDTH:0] out_result,
    output logic                          out_invalid,
    output logic                          out_divzero,
    input  logic                          flags_clr,
    output logic                          flag_invalid,
    output logic                          flag_divzero
);
    localparam int W = EXP_WIDTH + MANT_WIDTH + 1;
    localparam logic [W-2:0] INF_MAG = {{EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {CL_ZERO, CL_FIN, CL_INF, CL_NAN} cls_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    // Denormals count as finite nonzero unless flushed to zero by DAZ
    function automatic cls_t classify(input logic [W-1:0] x);
        if (x[W-2:MANT_WIDTH] == '1)
            return (x[MANT_WIDTH-1:0] == '0) ? CL_INF : CL_NAN;
        if (x[W-2:MANT_WIDTH] == '0 && (x[MANT_WIDTH-1:0] == '0 || DAZ))
            return CL_ZERO;
        return CL_FIN;
    endfunction

    logic   s1_valid;
    op_t    s1_op;
    cls_t   s1_ca, s1_cb;
    logic   s1_sa, s1_sb;
    logic   adv1, adv2;
    logic   sx, se;
    logic   res_special, res_invalid, res_divzero;
    logic [W-1:0] res_value;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = adv2 || !s1_valid;
    assign in_ready = adv1;

    // Stage 1: capture operand classes, signs and opcode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_ca    <= CL_ZERO;
            s1_cb    <= CL_ZERO;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op_t'(op);
                s1_ca <= classify(op1);
                s1_cb <= classify(op2);
                s1_sa <= op1[W-1];
                s1_sb <= op2[W-1];
            end
        end
    end

    // Resolve the special-case result from the stage-1 classes
    always_comb begin
        res_special = 1'b1;
        res_value   = '0;
        res_invalid = 1'b0;
        res_divzero = 1'b0;
        sx          = s1_sa ^ s1_sb;
        se          = s1_sb ^ (s1_op == OP_SUB);
        if (s1_ca == CL_NAN || s1_cb == CL_NAN) begin
            res_value = QNAN;
        end else if (s1_op == OP_ADD || s1_op == OP_SUB) begin
            if (s1_ca == CL_INF && s1_cb == CL_INF && s1_sa != se) begin
                res_value   = QNAN;
                res_invalid = 1'b1;
            end else if (s1_ca == CL_INF) begin
                res_value = {s1_sa, INF_MAG};
            end else if (s1_cb == CL_INF) begin
                res_value = {se, INF_MAG};
            end else if (s1_ca == CL_ZERO && s1_cb == CL_ZERO) begin
                res_value = {s1_sa & se, {(W-1){1'b0}}};
            end else begin
                res_special = 1'b0;
            end
        end else if (s1_op == OP_MUL) begin
            if ((s1_ca == CL_INF && s1_cb == CL_ZERO) || (s1_ca == CL_ZERO && s1_cb == CL_INF)) begin
                res_value   = QNAN;
                res_invalid = 1'b1;
            end else if (s1_ca == CL_INF || s1_cb == CL_INF) begin
                res_value = {sx, INF_MAG};
            end else if (s1_ca == CL_ZERO || s1_cb == CL_ZERO) begin
                res_value = {sx, {(W-1){1'b0}}};
            end else begin
                res_special = 1'b0;
            end
        end else begin
            if (s1_ca == s1_cb && (s1_ca == CL_ZERO || s1_ca == CL_INF)) begin
                res_value   = QNAN;
                res_invalid = 1'b1;
            end else if (s1_ca == CL_INF) begin
                res_value = {sx, INF_MAG};
            end else if (s1_cb == CL_ZERO) begin
                res_value   = {sx, INF_MAG};
                res_divzero = 1'b1;
            end else if (s1_ca == CL_ZERO || s1_cb == CL_INF) begin
                res_value = {sx, {(W-1){1'b0}}};
            end else begin
                res_special = 1'b0;
            end
        end
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_special <= 1'b0;
            out_result  <= '0;
            out_invalid <= 1'b0;
            out_divzero <= 1'b0;
        end else if (adv2) begin
            out_valid   <= s1_valid;
            out_special <= s1_valid & res_special;
            out_result  <= s1_valid ? res_value : '0;
            out_invalid <= s1_valid & res_invalid;
            out_divzero <= s1_valid & res_divzero;
        end
    end

    // Sticky flags: set on output transfer, clear wins only when nothing sets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_invalid <= 1'b0;
            flag_divzero <= 1'b0;
        end else begin
            flag_invalid <= (flag_invalid & !flags_clr) | (out_valid & out_ready & out_invalid);
            flag_divzero <= (flag_divzero & !flags_clr) | (out_valid & out_ready & out_divzero);
        end
    end
endmodule

// File: tb/tb_fp_special_case_unit.sv
// tb_fp_special_case_unit: directed and randomized checks of the special-case unit
module tb_fp_special_case_unit;
    localparam int N   = 200;
    localparam int PH0 = 40;
    localparam int PH1 = 70;

    typedef struct packed {
        logic        sp;
        logic        inv;
        logic        dz;
        logic [31:0] r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        out_ready = 1'b0;
    logic        flags_clr = 1'b0;
    logic        in_ready, out_valid, out_special, out_invalid, out_divzero, flag_invalid, flag_divzero;
    logic [31:0] out_result;
    logic        d_in_ready, d_out_valid, d_out_special, d_out_invalid, d_out_divzero, d_flag_invalid, d_flag_divzero;
    logic [31:0] d_out_result;

    int n_asserts = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_special_case_unit #(.EXP_WIDTH(8), .MANT_WIDTH(23), .DAZ(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
        .out_special(out_special), .out_result(out_result), .out_invalid(out_invalid),
        .out_divzero(out_divzero), .flags_clr(flags_clr), .flag_invalid(flag_invalid),
        .flag_divzero(flag_divzero)
    );

    fp_special_case_unit #(.EXP_WIDTH(8), .MANT_WIDTH(23), .DAZ(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready), .op(op),
        .op1(op1), .op2(op2), .out_valid(d_out_valid), .out_ready(out_ready),
        .out_special(d_out_special), .out_result(d_out_result), .out_invalid(d_out_invalid),
        .out_divzero(d_out_divzero), .flags_clr(flags_clr), .flag_invalid(d_flag_invalid),
        .flag_divzero(d_flag_divzero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_asserts++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // 0 zero, 1 finite nonzero, 2 infinity, 3 NaN
    function automatic int kind(input logic [31:0] x, input bit daz);
        int e;
        int m;
        e = int'(x[30:23]);
        m = int'(x[22:0]);
        if (e == 255) return (m == 0) ? 2 : 3;
        if (e == 0 && (m == 0 || daz)) return 0;
        return 1;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit daz);
        exp_t e;
        int   ka, kb;
        bit   sa, sb, sx;
        ka = kind(a, daz);
        kb = kind(b, daz);
        sa = a[31];
        sb = b[31] ^ (o == 2'd1);
        sx = a[31] ^ b[31];
        e = '{sp: 1'b1, inv: 1'b0, dz: 1'b0, r: 32'h0};
        if (ka == 3 || kb == 3) e.r = 32'h7FC00000;
        else if (o <= 2'd1) begin
            if (ka == 2 && kb == 2 && sa != sb) begin e.r = 32'h7FC00000; e.inv = 1'b1; end
            else if (ka == 2 || kb == 2) e.r = (ka == 2) ? {sa, 31'h7F800000} : {sb, 31'h7F800000};
            else if (ka + kb == 0) e.r = {sa & sb, 31'h0};
            else e.sp = 1'b0;
        end else if (o == 2'd2) begin
            if (ka * kb == 0 && ka + kb == 2 && ka != 1) begin e.r = 32'h7FC00000; e.inv = 1'b1; end
            else if (ka == 2 || kb == 2) e.r = {sx, 31'h7F800000};
            else if (ka * kb == 0) e.r = {sx, 31'h0};
            else e.sp = 1'b0;
        end else begin
            if (ka == kb && ka != 1) begin e.r = 32'h7FC00000; e.inv = 1'b1; end
            else if (ka == 2) e.r = {sx, 31'h7F800000};
            else if (kb == 0) begin e.r = {sx, 31'h7F800000}; e.dz = 1'b1; end
            else if (ka == 0 || kb == 2) e.r = {sx, 31'h0};
            else e.sp = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int k;
        k = $urandom_range(0, 4);
        v[31] = 1'($urandom_range(0, 1));
        case (k)
            0: v[30:0] = '0;
            1: begin v[30:23] = 8'h00; v[22:0] = 23'($urandom_range(1, 23'h7FFFFF)); end
            2: v[30:0] = 31'h7F800000;
            3: begin v[30:23] = 8'hFF; v[22:0] = 23'($urandom_range(1, 23'h7FFFFF)); end
            default: begin v[30:23] = 8'($urandom_range(1, 254)); v[22:0] = 23'($urandom); end
        endcase
        return v;
    endfunction

    task automatic send_check(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic sp, input logic [31:0] r, input logic inv, input logic dz);
        @(negedge clk);
        in_valid = 1'b1; op = o; op1 = a; op2 = b; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_out"}, 64'({out_special, out_invalid, out_divzero, out_result}), 64'({sp, inv, dz, r}));
    endtask

    initial begin
        exp_t        q[$];
        exp_t        e;
        logic [34:0] prev_out;
        bit          stalled, pop;
        logic        fi, fd;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outs", 64'({out_special, out_invalid, out_divzero, out_result}), 64'd0);
        check("rst_flags", 64'({flag_invalid, flag_divzero}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        send_check("mul_inf_zero", 2'd2, 32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000, 1'b1, 1'b0);
        @(negedge clk);
        check("flag_inv_set", 64'(flag_invalid), 64'd1);

        send_check("div_m1_zero", 2'd3, 32'hBF800000, 32'h00000000, 1'b1, 32'hFF800000, 1'b0, 1'b1);
        @(negedge clk);
        check("flag_dz_set", 64'(flag_divzero), 64'd1);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        check("flag_dz_clr", 64'(flag_divzero), 64'd0);
        check("flag_inv_clr", 64'(flag_invalid), 64'd0);

        send_check("sub_inf_inf", 2'd1, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1, 1'b0);
        send_check("add_nz_nz", 2'd0, 32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 1'b0);
        send_check("add_normal", 2'd0, 32'h3F800000, 32'h40000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        send_check("mul_den_ninf", 2'd2, 32'h00000001, 32'hFF800000, 1'b1, 32'hFF800000, 1'b0, 1'b0);
        check("daz_mul_den_ninf", 64'({d_out_special, d_out_invalid, d_out_divzero, d_out_result}),
              64'({1'b1, 1'b1, 1'b0, 32'h7FC00000}));

        stalled = 1'b0;
        prev_out = '0;
        fi = 1'b0;
        fd = 1'b0;
        for (int i = 0; i < N + 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("s_flag_inv", 64'(flag_invalid), 64'(fi));
                check("s_flag_dz", 64'(flag_divzero), 64'(fd));
            end
            if (stalled) check("s_stable", 64'({out_special, out_invalid, out_divzero, out_result}), 64'(prev_out));
            if (i >= PH0 + 2 && i < PH1) check("s_thruput", 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (q.size() == 0) check("s_spurious", 64'(out_valid), 64'd0);
                else check("s_result", 64'({out_special, out_invalid, out_divzero, out_result}), 64'(q[0]));
            end
            if (i < N) begin
                in_valid  = (i < 8) || (i >= PH0 && i < PH1) || ($urandom_range(0, 3) != 0);
                op        = 2'($urandom_range(0, 3));
                op1       = rand_operand();
                op2       = rand_operand();
                out_ready = (i >= PH0 && i < PH1) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            flags_clr = (i == 0) || (i < N && $urandom_range(0, 15) == 0);
            #1;
            pop = out_valid && out_ready && q.size() > 0;
            e = pop ? q.pop_front() : '0;
            fi = (flags_clr ? 1'b0 : fi) | (pop & e.inv);
            fd = (flags_clr ? 1'b0 : fd) | (pop & e.dz);
            if (in_valid && in_ready) q.push_back(model(op, op1, op2, 1'b0));
            stalled = out_valid && !out_ready;
            prev_out = {out_special, out_invalid, out_divzero, out_result};
        end
        flags_clr = 1'b0;
        check("s_drained", 64'(q.size()), 64'd0);

        send_check("pre_rst", 2'd2, 32'hFF800000, 32'h80000000, 1'b1, 32'h7FC00000, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; op = 2'd3; op1 = 32'h3F800000; op2 = 32'h00000000; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_outs", 64'({out_special, out_invalid, out_divzero, out_result}), 64'd0);
        check("mid_rst_flags", 64'({flag_invalid, flag_divzero}), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        send_check("post_rst_add", 2'd0, 32'h3F800000, 32'h40000000, 1'b0, 32'h00000000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
